// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// operand bypass select codes and the stall counter ceiling.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 8;

    // Memory-wait FSM states
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    // ID operand bypass selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] ID_rs, ID_rt;
    logic             ID_UseRs, ID_UseRt;
    logic             ID_BranchTaken;
    logic             EXE_RegWrite, EXE_M2Reg;
    logic [REG_W-1:0] EXE_TargetReg;
    logic             MEM_RegWrite, MEM_M2Reg, MEM_MemWrite;
    logic [REG_W-1:0] MEM_TargetReg;
    logic             mem_ready;

    logic [1:0]       FwdA, FwdB;
    logic             PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
    logic             ID_EXE_bubble;
    logic             IF_ID_flush;
    logic             mem_req;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_BranchTaken,
               EXE_RegWrite, EXE_M2Reg, EXE_TargetReg,
               MEM_RegWrite, MEM_M2Reg, MEM_MemWrite, MEM_TargetReg, mem_ready,
        input  FwdA, FwdB, PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
               ID_EXE_bubble, IF_ID_flush, mem_req, stall_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_BranchTaken,
               EXE_RegWrite, EXE_M2Reg, EXE_TargetReg,
               MEM_RegWrite, MEM_M2Reg, MEM_MemWrite, MEM_TargetReg, mem_ready,
        output FwdA, FwdB, PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
               ID_EXE_bubble, IF_ID_flush, mem_req, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Per-operand compare logic: picks the bypass source for one ID source
// register and flags a load-use dependency on it.
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic             exe_rw,
    input  logic             exe_m2r,
    input  logic [REG_W-1:0] exe_tgt,
    input  logic             mem_rw,
    input  logic [REG_W-1:0] mem_tgt,
    output logic [1:0]       fwd,
    output logic             load_use
);

    logic exe_hit, mem_hit;

    // r0 is hardwired zero, so a write to it never produces a match
    assign exe_hit = exe_rw && (exe_tgt != '0) && (exe_tgt == src);
    assign mem_hit = mem_rw && (mem_tgt != '0) && (mem_tgt == src);

    // EXE wins over MEM; a load in EXE has no data yet and is never bypassed
    always_comb begin
        fwd = FWD_RF;
        if (exe_hit && !exe_m2r)
            fwd = FWD_EXE;
        else if (mem_hit)
            fwd = FWD_MEM;
        load_use = use_src && exe_hit && exe_m2r;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: ID operand bypass selects, load-use bubble,
// branch flush and a RUN/MEM_WAIT freeze for slow data memory.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               clrn,
    pipe_hazard_ctrl_if.slave  hz
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_a, lu_b;
    logic mem_acc, wait_enter, wait_active, freeze, load_use;

    fwd_unit u_fwd_rs (
        .src      (hz.ID_rs),
        .use_src  (hz.ID_UseRs),
        .exe_rw   (hz.EXE_RegWrite),
        .exe_m2r  (hz.EXE_M2Reg),
        .exe_tgt  (hz.EXE_TargetReg),
        .mem_rw   (hz.MEM_RegWrite),
        .mem_tgt  (hz.MEM_TargetReg),
        .fwd      (hz.FwdA),
        .load_use (lu_a)
    );

    fwd_unit u_fwd_rt (
        .src      (hz.ID_rt),
        .use_src  (hz.ID_UseRt),
        .exe_rw   (hz.EXE_RegWrite),
        .exe_m2r  (hz.EXE_M2Reg),
        .exe_tgt  (hz.EXE_TargetReg),
        .mem_rw   (hz.MEM_RegWrite),
        .mem_tgt  (hz.MEM_TargetReg),
        .fwd      (hz.FwdB),
        .load_use (lu_b)
    );

    // Stall/flush decode; a memory freeze overrides load-use and flush, and
    // the mem_ready cycle of a wait releases every stage at once
    always_comb begin
        mem_acc     = hz.MEM_M2Reg || hz.MEM_MemWrite;
        wait_enter  = (state_q == ST_RUN) && mem_acc && !hz.mem_ready;
        wait_active = (state_q == ST_MEM_WAIT) || wait_enter;
        freeze      = wait_active && !hz.mem_ready;
        load_use    = (state_q == ST_RUN) && (lu_a || lu_b);

        hz.PC_en         = !freeze && !load_use;
        hz.IF_ID_en      = !freeze && !load_use;
        hz.ID_EXE_en     = !freeze;
        hz.EXE_MEM_en    = !freeze;
        hz.MEM_WB_en     = !freeze;
        hz.ID_EXE_bubble = !freeze && load_use;
        hz.IF_ID_flush   = hz.ID_BranchTaken && !load_use && !wait_active;
        hz.mem_req       = mem_acc || (state_q == ST_MEM_WAIT);
        hz.stall_cnt     = stall_cnt_q;
    end

    // Next state and saturating freeze-cycle count
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (wait_enter)   state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (hz.mem_ready) state_d = ST_RUN;
            default:                       state_d = ST_RUN;
        endcase
        stall_cnt_d = stall_cnt_q;
        if (freeze && (stall_cnt_q != STALL_MAX))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // FSM and counter registers; reset abandons any pending wait
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; ports: clk (rising edge), clrn (active-low, asynchronous).
REQ-002 Ports SHALL be:
- clk  in  1  pipeline clock.
- clrn  in  1  asynchronous active-low reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1 each  ID instruction reads rs / rt.
- ID_BranchTaken  in  1  branch resolved taken in ID.
- EXE_RegWrite, EXE_M2Reg  in  1 each  EXE-stage controls.
- EXE_TargetReg  in  5  EXE destination register.
- MEM_RegWrite, MEM_M2Reg, MEM_MemWrite  in  1 each  MEM-stage controls.
- MEM_TargetReg  in  5  MEM destination register.
- mem_ready  in  1  data memory completes the current access this cycle.
- FwdA, FwdB  out  2 each  ID operand bypass select: 00 register file, 01 EXE result, 10 MEM result.
- PC_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en  out  1 each  pipeline register load enables.
- ID_EXE_bubble  out  1  load zero controls into ID/EXE.
- IF_ID_flush  out  1  load a NOP into IF/ID.
- mem_req  out  1  data memory access request.
- stall_cnt  out  8  saturating count of memory-wait cycles.

Function
REQ-003 A forward SHALL be selected only when RegWrite=1 and TargetReg!=0 and TargetReg equals the source; the EXE match (01) SHALL take priority over the MEM match (10).
REQ-004 The EXE match SHALL be suppressed when EXE_M2Reg=1; load data is never bypassed from EXE.
REQ-005 A load-use hazard SHALL be EXE_RegWrite & EXE_M2Reg & EXE_TargetReg!=0 & ((ID_UseRs & rs match) | (ID_UseRt & rt match)).
REQ-006 On a load-use hazard in RUN: PC_en=0, IF_ID_en=0, ID_EXE_bubble=1, and all other enables=1, for exactly one cycle per hazard.
REQ-007 IF_ID_flush SHALL equal ID_BranchTaken when neither a load-use hazard nor a memory wait is active; otherwise it SHALL be 0.
REQ-008 mem_req SHALL equal MEM_M2Reg | MEM_MemWrite and SHALL stay high throughout MEM_WAIT.
REQ-009 The FSM SHALL have two states, RUN and MEM_WAIT.
- RUN->MEM_WAIT: mem_req & !mem_ready.
- MEM_WAIT->RUN: mem_ready.
- Otherwise the FSM holds its state.
REQ-010 A memory wait SHALL be active whenever the FSM is in MEM_WAIT or the RUN->MEM_WAIT condition holds.
- All five enables SHALL be 0, and ID_EXE_bubble and IF_ID_flush SHALL be 0.
- The freeze SHALL override REQ-006 and REQ-007.
REQ-011 In the cycle mem_ready is sampled high during MEM_WAIT, all enables SHALL be 1, so the pipeline advances in that same cycle.
REQ-012 stall_cnt SHALL increment by 1 on every cycle in which the freeze of REQ-010 is active, and SHALL saturate at 255 with no wrap.
REQ-013 Forwarding outputs SHALL be combinational, with zero latency; only the FSM state and stall_cnt are registered.

Reset
REQ-014 When clrn=0: state=RUN and stall_cnt=0, immediately and independently of clk.
REQ-015 With the FSM in RUN after reset, the outputs are set by REQ-003..REQ-010 from the inputs: with no hazard or memory access, all enables=1 and FwdA=FwdB=ID_EXE_bubble=IF_ID_flush=mem_req=0.
REQ-016 Reset asserted during MEM_WAIT SHALL abandon the wait and return the FSM to RUN.

Structure
REQ-017 The FSM state encoding and the Fwd select codes (00/01/10) SHALL be constants in the shared pipeline package.
REQ-018 The forwarding/hazard compare logic SHALL be one sub-module, fwd_unit, instantiated once for rs and once for rt.

Verification
REQ-019 EXE_RegWrite=1, EXE_TargetReg=5, EXE_M2Reg=0, ID_rs=5 -> FwdA=01; repeat with EXE_TargetReg=0 -> FwdA=00.
REQ-020 EXE and MEM both write register 7, ID_rt=7 -> FwdB=01; clear EXE_RegWrite -> FwdB=10.
REQ-021 EXE load to register 3, ID_rs=3, ID_UseRs=1 -> one cycle of PC_en=0, IF_ID_en=0, ID_EXE_bubble=1; the next cycle gives FwdA=10.
REQ-022 MEM_M2Reg=1 with mem_ready low for 3 cycles then high:
- all enables are 0 for 3 cycles, then 1 in the mem_ready cycle;
- stall_cnt goes 0->3;
- a concurrent ID_BranchTaken gives IF_ID_flush=0 while frozen.
REQ-023 Hold MEM_WAIT for 300 cycles -> stall_cnt=255; pulse clrn low mid-wait -> state=RUN and stall_cnt=0 asynchronously.
